hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_msb_index.sv | 25 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: signed slot index with a -1 "no slot"
// encoding, controller state enum and 1-bit flag helpers.
`ifndef HAZARD_CTRL_FLAGS
`define HAZARD_CTRL_FLAGS
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package hazard_ctrl_pkg;

  typedef logic bool;

  localparam int MAX_SLOTS  = 64;
  localparam int SLOT_IDX_W = $clog2(MAX_SLOTS) + 1;

  typedef logic signed [SLOT_IDX_W-1:0] slot_idx_t;

  localparam slot_idx_t NO_SLOT = slot_idx_t'(-1);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_msb_index.sv
// Highest-set-bit encoder: returns the index of the most significant set bit of vec,
// or NO_SLOT with valid low when vec is all zeros.
module msb_index
  import hazard_ctrl_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] vec,
  output slot_idx_t        idx,
  output bool              valid
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx   = NO_SLOT;
    valid = `FALSE;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx   = slot_idx_t'(i);
        valid = `TRUE;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns per-slot stall/flush requests into per-slot hold/clear
// commands, defers flushes stuck behind older stalls, holds fetch flushed after a redirect.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS  = 7,
  parameter int FLUSH_HOLD = 2,
  parameter int CNT_W      = 32,
  parameter int WDOG_CYC   = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_SLOTS-1:0] stall_req,
  input  logic [NUM_SLOTS-1:0] flush_req,
  output logic [NUM_SLOTS-1:0] stall,
  output logic [NUM_SLOTS-1:0] flush,
  output logic [NUM_SLOTS-1:0] flush_ack,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic                 wedge
);

  localparam int HOLD_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  hz_state_e           state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  bool                 pend_valid_q, pend_valid_d;
  slot_idx_t           pend_idx_q, pend_idx_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  bool                 wedge_q, wedge_d;

  logic [NUM_SLOTS-1:0] flush_vec;
  slot_idx_t            s_idx, f_idx;
  bool                  s_valid, f_valid, apply;

  // The pending flush re-enters arbitration alongside fresh requests.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      flush_vec[i] = flush_req[i] | (pend_valid_q && (pend_idx_q == slot_idx_t'(i)));
    end
  end

  msb_index #(.WIDTH(NUM_SLOTS)) u_stall_msb (
    .vec   (stall_req),
    .idx   (s_idx),
    .valid (s_valid)
  );

  msb_index #(.WIDTH(NUM_SLOTS)) u_flush_msb (
    .vec   (flush_vec),
    .idx   (f_idx),
    .valid (f_valid)
  );

  // s_idx is NO_SLOT (-1) when nothing stalls, so a signed compare covers that case.
  assign apply = f_valid && (f_idx > s_idx);

  always_comb begin
    stall     = '0;
    flush     = '0;
    flush_ack = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (s_valid && (slot_idx_t'(i) <= s_idx)) stall[i] = 1'b1;
      if (!apply && s_valid && (slot_idx_t'(i) == s_idx + slot_idx_t'(1))) flush[i] = 1'b1;
      if (apply && (slot_idx_t'(i) < f_idx)) begin
        flush[i] = 1'b1;
        stall[i] = 1'b0;
      end
      if (apply && (slot_idx_t'(i) == f_idx)) flush_ack[i] = 1'b1;
    end
    if (state_q == HOLD) begin
      flush[0] = 1'b1;
      stall[0] = 1'b0;
    end
    if (!resetn) begin
      stall     = '0;
      flush     = '1;
      flush_ack = '0;
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    pend_valid_d   = pend_valid_q;
    pend_idx_d     = pend_idx_q;
    stall_cycles_d = stall_cycles_q;
    wdog_d         = wdog_q;

    if (apply) begin
      pend_valid_d = `FALSE;
      pend_idx_d   = NO_SLOT;
    end else if (f_valid) begin
      // f already folds in the pending index, so this is max(pend_idx, new request).
      pend_valid_d = `TRUE;
      pend_idx_d   = f_idx;
    end

    if (apply && (FLUSH_HOLD > 0)) begin
      state_d    = HOLD;
      hold_cnt_d = HOLD_W'(FLUSH_HOLD);
    end else if (state_q == HOLD) begin
      if (hold_cnt_q <= HOLD_W'(1)) begin
        state_d    = RUN;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
    end

    if ((|stall) && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);

    if (stall_req == '0)                    wdog_d = '0;
    else if (wdog_q != WDOG_W'(WDOG_CYC))   wdog_d = wdog_q + WDOG_W'(1);

    wedge_d = wedge_q | (wdog_d == WDOG_W'(WDOG_CYC));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= RUN;
      hold_cnt_q     <= '0;
      pend_valid_q   <= `FALSE;
      pend_idx_q     <= NO_SLOT;
      stall_cycles_q <= '0;
      wdog_q         <= '0;
      wedge_q        <= `FALSE;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      pend_valid_q   <= pend_valid_d;
      pend_idx_q     <= pend_idx_d;
      stall_cycles_q <= stall_cycles_d;
      wdog_q         <= wdog_d;
      wedge_q        <= wedge_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign wedge        = wedge_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle vector table of requests and expected commands,
// plus hand sequences for the watchdog and reset-discard corner cases.
module tb_hazard_ctrl;
  localparam int N = 7;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] stall_req = '0;
  logic [N-1:0] flush_req = '0;
  logic [N-1:0] stall, flush, flush_ack;
  logic [31:0]  stall_cycles;
  logic         wedge;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NUM_SLOTS  (N),
    .FLUSH_HOLD (2),
    .CNT_W      (32),
    .WDOG_CYC   (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall_req    (stall_req),
    .flush_req    (flush_req),
    .stall        (stall),
    .flush        (flush),
    .flush_ack    (flush_ack),
    .stall_cycles (stall_cycles),
    .wedge        (wedge)
  );

  typedef struct {
    logic         rn;
    logic [N-1:0] sr;
    logic [N-1:0] fr;
    logic [N-1:0] st;
    logic [N-1:0] fl;
    logic [N-1:0] ack;
    int           cyc;
    logic         wdg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample mid-low-phase, well away from the rising edge.
  task automatic drive(input logic rn, input logic [N-1:0] sr, input logic [N-1:0] fr);
    @(negedge clk);
    resetn    = rn;
    stall_req = sr;
    flush_req = fr;
    #2;
  endtask

  task automatic add(input logic rn, input logic [N-1:0] sr, input logic [N-1:0] fr,
                     input logic [N-1:0] st, input logic [N-1:0] fl, input logic [N-1:0] ack,
                     input int cyc);
    vec_t v;
    v.rn = rn; v.sr = sr; v.fr = fr; v.st = st; v.fl = fl; v.ack = ack; v.cyc = cyc; v.wdg = 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    //  rn   stall_req   flush_req   stall       flush       ack         cyc
    add(0, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111, 7'b0000000, 0);  // 0 reset
    add(0, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111, 7'b0000000, 0);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 0);  // 2 idle
    add(1, 7'b0010000, 7'b0000000, 7'b0011111, 7'b0100000, 7'b0000000, 0);  // 3 stall at 4
    add(1, 7'b0010000, 7'b0000000, 7'b0011111, 7'b0100000, 7'b0000000, 1);
    add(1, 7'b0010000, 7'b0000000, 7'b0011111, 7'b0100000, 7'b0000000, 2);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 3);
    add(1, 7'b0000000, 7'b0001000, 7'b0000000, 7'b0000111, 7'b0001000, 3);  // 7 flush at 3
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 3);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 3);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 3);
    add(1, 7'b0100000, 7'b0001000, 7'b0111111, 7'b1000000, 7'b0000000, 3);  // 11 deferred
    add(1, 7'b0100000, 7'b0000000, 7'b0111111, 7'b1000000, 7'b0000000, 4);
    add(1, 7'b0100000, 7'b0000000, 7'b0111111, 7'b1000000, 7'b0000000, 5);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000111, 7'b0001000, 6);  // 14 pend applied
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 6);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 6);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 6);
    add(1, 7'b0000000, 7'b0010100, 7'b0000000, 7'b0001111, 7'b0010000, 6);  // 18 oldest wins
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 6);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 6);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 6);
    add(1, 7'b0000100, 7'b0000100, 7'b0000111, 7'b0001000, 7'b0000000, 6);  // 22 same slot
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000011, 7'b0000100, 7);
    add(1, 7'b0100000, 7'b0010000, 7'b0111110, 7'b1000001, 7'b0000000, 7);  // 24 defer in HOLD
    add(1, 7'b0100000, 7'b0000010, 7'b0111110, 7'b1000001, 7'b0000000, 8);  // 25 absorbed
    add(1, 7'b0000100, 7'b0000000, 7'b0000000, 7'b0001111, 7'b0010000, 9);  // 26 f=4 > s=2
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b1000000, 7'b0000000, 7'b0111111, 7'b1000000, 9);  // 30 flush at top
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b0000001, 7'b0000000, 7'b0000000, 7'b0000001, 9);  // 34 flush at 0
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 9);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 9);
    add(1, 7'b1000000, 7'b0000000, 7'b1111111, 7'b0000000, 7'b0000000, 9);  // 38 stall at top
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 10);
    add(1, 7'b0000000, 7'b0000100, 7'b0000000, 7'b0000011, 7'b0000100, 10); // 40 hold reload
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 10);
    add(1, 7'b0000000, 7'b0001000, 7'b0000000, 7'b0000111, 7'b0001000, 10);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 10);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000, 10);
    add(1, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 10);

    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].sr, vecs[i].fr);
      check($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].st));
      check($sformatf("v%0d.flush", i), 32'(flush), 32'(vecs[i].fl));
      check($sformatf("v%0d.flush_ack", i), 32'(flush_ack), 32'(vecs[i].ack));
      check($sformatf("v%0d.stall_cycles", i), stall_cycles, 32'(vecs[i].cyc));
      check($sformatf("v%0d.wedge", i), 32'(wedge), 32'(vecs[i].wdg));
    end

    // Watchdog: stall held on slot 1, wedge appears in the 9th stalled cycle and is sticky.
    for (int c = 0; c <= 8; c++) begin
      drive(1'b1, 7'b0000010, 7'b0000000);
      check($sformatf("wdog.c%0d.wedge", c), 32'(wedge), (c == 8) ? 32'd1 : 32'd0);
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 7'b0000000, 7'b0000000);
      check($sformatf("wdog.sticky%0d", c), 32'(wedge), 32'd1);
    end
    drive(1'b0, 7'b0000000, 7'b0000000);
    drive(1'b1, 7'b0000000, 7'b0000000);
    check("wdog.reset.wedge", 32'(wedge), 32'd0);
    check("wdog.reset.stall_cycles", stall_cycles, 32'd0);

    // Reset while in HOLD with a deferred flush pending: both are dropped, no ack ever appears.
    drive(1'b1, 7'b0000000, 7'b0001000);
    check("rst_hold.apply.ack", 32'(flush_ack), 32'(7'b0001000));
    check("rst_hold.apply.flush", 32'(flush), 32'(7'b0000111));
    drive(1'b1, 7'b0100000, 7'b0001000);
    check("rst_hold.defer.ack", 32'(flush_ack), 32'd0);
    check("rst_hold.defer.flush", 32'(flush), 32'(7'b1000001));
    drive(1'b0, 7'b0100000, 7'b0000000);
    check("rst_hold.inreset.stall", 32'(stall), 32'd0);
    check("rst_hold.inreset.flush", 32'(flush), 32'(7'b1111111));
    check("rst_hold.inreset.ack", 32'(flush_ack), 32'd0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 7'b0000000, 7'b0000000);
      check($sformatf("rst_hold.after%0d.flush", c), 32'(flush), 32'd0);
      check($sformatf("rst_hold.after%0d.ack", c), 32'(flush_ack), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
